// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake between the debug control processor and the UART transmitter FIFO.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] d_tx;
   logic                 vld_tx;
   logic                 rdy_tx;

   modport master (output d_tx, output vld_tx, input rdy_tx);
   modport slave  (input d_tx, input vld_tx, output rdy_tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 5..9 data bits, optional odd/even parity, 1 or 2 stop bits,
// internal baud counter, back-to-back frames while the FIFO holds data.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 wr,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          ovf,
   input  logic                          ovf_clr
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic [2:0]           state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;

   logic full, empty, push, pop, baud_end;

   // Write acceptance looks only at the registered count, so a same-edge pop never frees room.
   assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign empty    = (cnt_q == '0);
   assign push     = wr.vld_tx && !full;
   assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_end ? '0 : baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      txd_d   = txd_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            pop    = !empty;
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               txd_d   = shreg_q[0];
            end
         end
         S_DATA: begin
            if (baud_end) begin
               shreg_d = shreg_q >> 1;
               par_d   = par_q ^ shreg_q[0];
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = S_PAR;
                     txd_d   = par_q ^ shreg_q[0];
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
                  txd_d = shreg_q[1];
               end
            end
         end
         S_PAR: begin
            if (baud_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               txd_d   = 1'b1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  if (!empty) begin
                     pop = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
         end
      endcase
      // Loading the head starts the start bit on the same edge; parity seeds to 1 for odd.
      if (pop) begin
         shreg_d = mem_q[rd_ptr_q];
         par_d   = (PARITY == 1);
         txd_d   = 1'b0;
         state_d = S_START;
         bit_d   = '0;
         baud_d  = '0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
      ovf_d = ovf_q;
      if (wr.vld_tx && full) ovf_d = 1'b1;
      else if (ovf_clr)      ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         txd_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         txd_q    <= txd_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // Datapath storage carries no reset; validity is tracked by the control flops above.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      if (!rst && push) mem_q[wr_ptr_q] <= wr.d_tx;
   end

   assign wr.rdy_tx = !full;
   assign txd       = txd_q;
   assign busy      = (state_q != S_IDLE) || !empty;
   assign fifo_cnt  = cnt_q;
   assign ovf       = ovf_q;

endmodule
